// File: rtl/mips_mc_pkg.sv
// Shared definitions for the multicycle MIPS controller: FSM states,
// opcode/funct constants and the encodings driven onto the datapath selects.
package mips_mc_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned ALU_W   = 4;
  localparam int unsigned SRCB_W  = 3;
  localparam int unsigned PCSRC_W = 2;

  typedef enum logic [STATE_W-1:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPE, ALUWB,
    BEQ, BNE, BLEZ, ADDIEX, ORIEX, IMMWB, JUMP, ILLEGAL
  } state_e;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BLEZ  = 6'b000110;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU operation encodings
  localparam logic [ALU_W-1:0] ALU_AND = 4'b0000;
  localparam logic [ALU_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [ALU_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [ALU_W-1:0] ALU_XOR = 4'b0011;
  localparam logic [ALU_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [ALU_W-1:0] ALU_SLT = 4'b0111;
  localparam logic [ALU_W-1:0] ALU_NOR = 4'b1100;

  // ALU source-B select
  localparam logic [SRCB_W-1:0] SRCB_B      = 3'b000;
  localparam logic [SRCB_W-1:0] SRCB_FOUR   = 3'b001;
  localparam logic [SRCB_W-1:0] SRCB_SIMM   = 3'b010;
  localparam logic [SRCB_W-1:0] SRCB_SIMMSH = 3'b011;
  localparam logic [SRCB_W-1:0] SRCB_ZIMM   = 3'b100;

  // PC source select
  localparam logic [PCSRC_W-1:0] PC_ALURES = 2'b00;
  localparam logic [PCSRC_W-1:0] PC_ALUOUT = 2'b01;
  localparam logic [PCSRC_W-1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_mc_aludec.sv
// R-type ALU decoder: maps funct to an ALU operation and flags unsupported functs.
//   funct       : instr[5:0]
//   alucontrol  : ALU operation (0 when funct is unsupported)
//   funct_valid : 1 when funct is one of the supported R-type operations
module mips_mc_aludec
  import mips_mc_pkg::*;
(
  input  logic [5:0]       funct,
  output logic [ALU_W-1:0] alucontrol,
  output logic             funct_valid
);

  always_comb begin
    alucontrol  = '0;
    funct_valid = 1'b1;
    case (funct)
      FN_ADD:  alucontrol = ALU_ADD;
      FN_SUB:  alucontrol = ALU_SUB;
      FN_AND:  alucontrol = ALU_AND;
      FN_OR:   alucontrol = ALU_OR;
      FN_XOR:  alucontrol = ALU_XOR;
      FN_NOR:  alucontrol = ALU_NOR;
      FN_SLT:  alucontrol = ALU_SLT;
      default: funct_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control unit. A single Moore FSM steps each instruction
// through fetch/decode/execute/memory/writeback and counts retired instructions.
//   clk, reset (async, active-low)
//   op, funct       : instruction fields from the instruction register
//   zero, ltez      : branch conditions from the datapath
//   memready        : memory completes its access this cycle
//   memreq .. pcen  : datapath strobes and selects (all 0 while reset is low)
//   alucontrol      : ALU operation
//   illegal_op      : one-cycle pulse on an unsupported op/funct
//   instret         : retired-instruction count, wraps modulo 2^CNT_W
module mips_mc_controller
  import mips_mc_pkg::*;
#(
  parameter int unsigned ALUCTRL_W     = 4,
  parameter int unsigned MEM_HANDSHAKE = 1,
  parameter int unsigned CNT_W         = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           op,
  input  logic [5:0]           funct,
  input  logic                 zero,
  input  logic                 ltez,
  input  logic                 memready,
  output logic                 memreq,
  output logic                 memwrite,
  output logic                 iord,
  output logic                 irwrite,
  output logic                 regdst,
  output logic                 memtoreg,
  output logic                 regwrite,
  output logic                 alusrca,
  output logic [SRCB_W-1:0]    alusrcb,
  output logic [PCSRC_W-1:0]   pcsrc,
  output logic                 pcen,
  output logic [ALUCTRL_W-1:0] alucontrol,
  output logic                 illegal_op,
  output logic [CNT_W-1:0]     instret
);

  localparam bit HANDSHAKE = (MEM_HANDSHAKE != 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             retire_c;
  logic             ready_c;
  logic [ALU_W-1:0] rtype_alu;
  logic             funct_valid;
  logic [ALU_W-1:0] alu_c;

  // Without the handshake every memory access completes in one cycle.
  assign ready_c = memready | ~HANDSHAKE;

  mips_mc_aludec u_aludec (
    .funct       (funct),
    .alucontrol  (rtype_alu),
    .funct_valid (funct_valid)
  );

  // State and retired-instruction registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  // Next-state and retirement
  always_comb begin
    state_d  = state_q;
    retire_c = 1'b0;
    case (state_q)
      FETCH:  if (ready_c) state_d = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = RTYPE;
          OP_BEQ:       state_d = BEQ;
          OP_BNE:       state_d = BNE;
          OP_BLEZ:      state_d = BLEZ;
          OP_ADDI:      state_d = ADDIEX;
          OP_ORI:       state_d = ORIEX;
          OP_J:         state_d = JUMP;
          default:      state_d = ILLEGAL;
        endcase
      end
      MEMADR: state_d = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  if (ready_c) state_d = MEMWB;
      MEMWR: begin
        if (ready_c) begin
          state_d  = FETCH;
          retire_c = 1'b1;
        end
      end
      RTYPE:  state_d = funct_valid ? ALUWB : ILLEGAL;
      ADDIEX, ORIEX: state_d = IMMWB;
      MEMWB, ALUWB, IMMWB, BEQ, BNE, BLEZ, JUMP: begin
        state_d  = FETCH;
        retire_c = 1'b1;
      end
      default: state_d = FETCH;
    endcase
    instret_d = retire_c ? instret_q + CNT_W'(1) : instret_q;
  end

  // Moore outputs; pcen/irwrite also see memready in FETCH and the flags in branches
  always_comb begin
    memreq     = 1'b0;
    memwrite   = 1'b0;
    iord       = 1'b0;
    irwrite    = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = '0;
    pcsrc      = '0;
    pcen       = 1'b0;
    alu_c      = '0;
    illegal_op = 1'b0;
    if (reset) begin
      case (state_q)
        FETCH: begin
          memreq  = 1'b1;
          alusrcb = SRCB_FOUR;
          alu_c   = ALU_ADD;
          pcsrc   = PC_ALURES;
          irwrite = ready_c;
          pcen    = ready_c;
        end
        DECODE: begin
          alusrcb = SRCB_SIMMSH;
          alu_c   = ALU_ADD;
        end
        MEMADR, ADDIEX: begin
          alusrca = 1'b1;
          alusrcb = SRCB_SIMM;
          alu_c   = ALU_ADD;
        end
        MEMRD: begin
          memreq = 1'b1;
          iord   = 1'b1;
        end
        MEMWB: begin
          regwrite = 1'b1;
          memtoreg = 1'b1;
        end
        MEMWR: begin
          memreq   = 1'b1;
          memwrite = 1'b1;
          iord     = 1'b1;
        end
        RTYPE: begin
          alusrca = 1'b1;
          alusrcb = SRCB_B;
          alu_c   = rtype_alu;
        end
        ALUWB: begin
          regwrite = 1'b1;
          regdst   = 1'b1;
        end
        BEQ, BNE, BLEZ: begin
          alusrca = 1'b1;
          alusrcb = SRCB_B;
          alu_c   = ALU_SUB;
          pcsrc   = PC_ALUOUT;
          pcen    = (state_q == BEQ) ? zero :
                    (state_q == BNE) ? ~zero : ltez;
        end
        ORIEX: begin
          alusrca = 1'b1;
          alusrcb = SRCB_ZIMM;
          alu_c   = ALU_OR;
        end
        IMMWB:   regwrite = 1'b1;
        JUMP: begin
          pcsrc = PC_JUMP;
          pcen  = 1'b1;
        end
        ILLEGAL: illegal_op = 1'b1;
        default: ;
      endcase
    end
  end

  assign alucontrol = ALUCTRL_W'(alu_c);
  assign instret    = instret_q;

endmodule

// File: tb/tb_mips_mc_controller.sv
// Self-checking bench for mips_mc_controller. A per-instruction timing model
// (phase lengths per instruction class) predicts every strobe each cycle.
module tb_mips_mc_controller;

  localparam int K_LW = 0, K_SW = 1, K_R = 2, K_RBAD = 3, K_BEQ = 4, K_BNE = 5,
                 K_BLEZ = 6, K_ADDI = 7, K_ORI = 8, K_J = 9, K_ILL = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance: handshake on, 32-bit counter
  logic reset, zero, ltez, memready;
  logic [5:0] op, funct;
  logic memreq, memwrite, iord, irwrite, regdst, memtoreg, regwrite, alusrca, pcen, illegal_op;
  logic [2:0] alusrcb;
  logic [1:0] pcsrc;
  logic [3:0] alucontrol;
  logic [31:0] instret;

  // Second instance: handshake off, memready tied low, 4-bit counter
  logic reset2;
  logic [5:0] op2;
  logic mr2_tie = 1'b0;
  logic memreq2, memwrite2, iord2, irwrite2, regdst2, memtoreg2, regwrite2, alusrca2, pcen2, illegal2;
  logic [2:0] alusrcb2;
  logic [1:0] pcsrc2;
  logic [3:0] alucontrol2;
  logic [3:0] instret2;

  mips_mc_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .ltez(ltez),
    .memready(memready), .memreq(memreq), .memwrite(memwrite), .iord(iord),
    .irwrite(irwrite), .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
    .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc), .pcen(pcen),
    .alucontrol(alucontrol), .illegal_op(illegal_op), .instret(instret)
  );

  mips_mc_controller #(.ALUCTRL_W(4), .MEM_HANDSHAKE(0), .CNT_W(4)) dut2 (
    .clk(clk), .reset(reset2), .op(op2), .funct(6'b100000), .zero(1'b0), .ltez(1'b0),
    .memready(mr2_tie), .memreq(memreq2), .memwrite(memwrite2), .iord(iord2),
    .irwrite(irwrite2), .regdst(regdst2), .memtoreg(memtoreg2), .regwrite(regwrite2),
    .alusrca(alusrca2), .alusrcb(alusrcb2), .pcsrc(pcsrc2), .pcen(pcen2),
    .alucontrol(alucontrol2), .illegal_op(illegal2), .instret(instret2)
  );

  // {memreq, memwrite, iord, irwrite, regdst, memtoreg, regwrite, pcsrc, pcen, illegal_op}
  logic [10:0] strb, strb2;
  logic [7:0]  sel, sel2;
  assign strb  = {memreq, memwrite, iord, irwrite, regdst, memtoreg, regwrite, pcsrc, pcen, illegal_op};
  assign strb2 = {memreq2, memwrite2, iord2, irwrite2, regdst2, memtoreg2, regwrite2, pcsrc2, pcen2, illegal2};
  assign sel   = {alusrca, alusrcb, alucontrol};
  assign sel2  = {alusrca2, alusrcb2, alucontrol2};

  int total = 0;
  int bad = 0;
  int model_ret = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // {valid, alu op} for an R-type funct
  function automatic logic [4:0] alu_ref(input logic [5:0] fn);
    case (fn)
      6'b100000: return 5'b1_0010;
      6'b100010: return 5'b1_0110;
      6'b100100: return 5'b1_0000;
      6'b100101: return 5'b1_0001;
      6'b100110: return 5'b1_0011;
      6'b100111: return 5'b1_1100;
      6'b101010: return 5'b1_0111;
      default:   return 5'b0_0000;
    endcase
  endfunction

  function automatic int classify(input logic [5:0] o, input logic [5:0] fn);
    logic [4:0] a;
    a = alu_ref(fn);
    case (o)
      6'b100011: return K_LW;
      6'b101011: return K_SW;
      6'b000000: return a[4] ? K_R : K_RBAD;
      6'b000100: return K_BEQ;
      6'b000101: return K_BNE;
      6'b000110: return K_BLEZ;
      6'b001000: return K_ADDI;
      6'b001101: return K_ORI;
      6'b000010: return K_J;
      default:   return K_ILL;
    endcase
  endfunction

  // Runs one instruction: sf fetch stall cycles, sm memory stall cycles.
  task automatic run(input logic [5:0] o, input logic [5:0] fn, input logic zf,
                     input logic lz, input int sf, input int sm);
    int kind, post, d;
    logic [4:0] a;
    logic taken, mr, memph, last, do_sel;
    logic [10:0] es;
    logic [7:0] esel;
    kind = classify(o, fn);
    a = alu_ref(fn);
    taken = (kind == K_BEQ) ? zf : (kind == K_BNE) ? ~zf : lz;
    case (kind)
      K_LW:                    post = 4 + sm;
      K_SW:                    post = 3 + sm;
      K_R, K_RBAD, K_ADDI, K_ORI: post = 3;
      default:                 post = 2;
    endcase
    op = o; funct = fn; zero = zf; ltez = lz;
    for (int c = 0; c < sf + 1 + post; c++) begin
      d = c - (sf + 1);
      memph = (kind == K_LW || kind == K_SW) && d >= 2 && d <= 2 + sm;
      last = (c == sf + post);
      if (c <= sf)    mr = (c == sf);
      else if (memph) mr = (d >= 2 + sm);
      else            mr = 1'($urandom);
      memready = mr;
      es = '0;
      if (c <= sf) begin
        es[10] = 1'b1; es[7] = mr; es[1] = mr;
      end
      if (memph) begin
        es[10] = 1'b1; es[8] = 1'b1; es[9] = (kind == K_SW);
      end
      if (last) begin
        es[4] = (kind == K_LW || kind == K_R || kind == K_ADDI || kind == K_ORI);
        es[5] = (kind == K_LW);
        es[6] = (kind == K_R);
        es[0] = (kind == K_RBAD || kind == K_ILL);
      end
      if (d == 1 && (kind == K_BEQ || kind == K_BNE || kind == K_BLEZ)) begin
        es[3:2] = 2'b01; es[1] = taken;
      end
      if (d == 1 && kind == K_J) begin
        es[3:2] = 2'b10; es[1] = 1'b1;
      end
      do_sel = 1'b1;
      if (c <= sf)      esel = {1'b0, 3'b001, 4'b0010};
      else if (d == 0)  esel = {1'b0, 3'b011, 4'b0010};
      else if (d == 1 && (kind == K_LW || kind == K_SW || kind == K_ADDI))
                        esel = {1'b1, 3'b010, 4'b0010};
      else if (d == 1 && kind == K_R)   esel = {1'b1, 3'b000, a[3:0]};
      else if (d == 1 && kind == K_ORI) esel = {1'b1, 3'b100, 4'b0001};
      else if (d == 1 && (kind == K_BEQ || kind == K_BNE || kind == K_BLEZ))
                        esel = {1'b1, 3'b000, 4'b0110};
      else begin
        esel = '0; do_sel = 1'b0;
      end
      @(negedge clk);
      if (c == 0) chk("instret", instret, model_ret);
      chk($sformatf("strobes op=%b fn=%b cyc=%0d", o, fn, c), 32'(strb), 32'(es));
      if (do_sel) chk($sformatf("selects op=%b fn=%b cyc=%0d", o, fn, c), 32'(sel), 32'(esel));
      @(posedge clk); #1;
    end
    if (kind != K_RBAD && kind != K_ILL) model_ret++;
  endtask

  logic [10:0] exp_lw2 [5];
  logic [5:0] rop, rfn;
  logic [5:0] valid_fn [7];

  initial begin
    exp_lw2[0] = 11'b10010000010;  // fetch: memreq, irwrite, pcen
    exp_lw2[1] = 11'b00000000000;  // decode
    exp_lw2[2] = 11'b00000000000;  // address
    exp_lw2[3] = 11'b10100000000;  // read: memreq, iord
    exp_lw2[4] = 11'b00000110000;  // writeback: memtoreg, regwrite
    valid_fn[0] = 6'b100000; valid_fn[1] = 6'b100010; valid_fn[2] = 6'b100100;
    valid_fn[3] = 6'b100101; valid_fn[4] = 6'b100110; valid_fn[5] = 6'b100111;
    valid_fn[6] = 6'b101010;

    reset = 1'b0; reset2 = 1'b0; op = 6'b100011; funct = '0; op2 = 6'b100011;
    zero = 1'b1; ltez = 1'b1; memready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("reset_strobes", 32'(strb), 32'd0);
      chk("reset_selects", 32'(sel), 32'd0);
      chk("reset_instret", instret, 32'd0);
    end
    @(posedge clk); #1 reset = 1'b1;

    // Directed instructions from the plan
    run(6'b100011, 6'b000000, 1'b0, 1'b0, 0, 0);  // lw, 5 cycles
    run(6'b101011, 6'b000000, 1'b0, 1'b0, 0, 3);  // sw, 3 stall cycles
    run(6'b000100, 6'b000000, 1'b1, 1'b0, 0, 0);  // beq taken
    run(6'b000101, 6'b000000, 1'b1, 1'b0, 0, 0);  // bne not taken
    run(6'b000110, 6'b000000, 1'b0, 1'b1, 0, 0);  // blez taken
    run(6'b000000, 6'b100111, 1'b0, 1'b0, 0, 0);  // nor
    run(6'b000000, 6'b111111, 1'b0, 1'b0, 0, 0);  // bad funct
    run(6'b111111, 6'b000000, 1'b0, 1'b0, 0, 0);  // bad op
    run(6'b001000, 6'b000000, 1'b0, 1'b0, 2, 0);  // addi, fetch stall
    run(6'b001101, 6'b000000, 1'b0, 1'b0, 0, 0);  // ori
    run(6'b000010, 6'b000000, 1'b0, 1'b0, 0, 0);  // j

    // Reset in the read phase of a lw
    op = 6'b100011; memready = 1'b1;
    repeat (3) @(posedge clk);
    #1 memready = 1'b0;
    @(negedge clk);
    chk("memrd_strobes", 32'(strb), 32'(11'b10100000000));
    chk("pre_reset_instret", instret, model_ret);
    reset = 1'b0; #1;
    chk("midreset_strobes", 32'(strb), 32'd0);
    chk("midreset_selects", 32'(sel), 32'd0);
    chk("midreset_instret", instret, 32'd0);
    model_ret = 0;
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("post_reset_fetch", 32'(strb), 32'(11'b10000000000));
    @(posedge clk); #1;
    run(6'b000010, 6'b000000, 1'b0, 1'b0, 0, 0);

    // Randomised instruction mix with random stalls and flags
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 11))
        0:  rop = 6'b100011;
        1:  rop = 6'b101011;
        2, 3: rop = 6'b000000;
        4:  rop = 6'b000100;
        5:  rop = 6'b000101;
        6:  rop = 6'b000110;
        7:  rop = 6'b001000;
        8:  rop = 6'b001101;
        9:  rop = 6'b000010;
        default: rop = 6'($urandom);
      endcase
      if ($urandom_range(0, 3) != 0) rfn = valid_fn[$urandom_range(0, 6)];
      else rfn = 6'($urandom);
      run(rop, rfn, 1'($urandom), 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 3));
    end

    // No-handshake instance: lw in 5 cycles with memready held low
    @(posedge clk); #1 reset2 = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("nohs_lw cyc=%0d", c), 32'(strb2), 32'(exp_lw2[c]));
      if (c == 0) chk("nohs_fetch_sel", 32'(sel2), 32'(8'b0_001_0010));
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("nohs_instret_lw", 32'(instret2), 32'd1);
    reset2 = 1'b0; #1;
    chk("nohs_instret_reset", 32'(instret2), 32'd0);
    @(posedge clk); #1 reset2 = 1'b1; op2 = 6'b000010;
    for (int j = 1; j <= 16; j++) begin
      repeat (3) @(posedge clk);
      #1;
      if (j >= 14) chk($sformatf("nohs_wrap j=%0d", j), 32'(instret2), 32'(j % 16));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_mc_controller.md
Name: mips_mc_controller

Overview:
- Multicycle MIPS control unit; successor to the single-cycle controller.
- One FSM sequences fetch, decode, execute, memory and writeback over 3–5 cycles per instruction.
- Adds a memory ready handshake, an illegal-opcode path, BNE/BLEZ/ORI, and a retired-instruction counter.
- Sits between the instruction register and the multicycle datapath, inside the mips top level.

Parameters:
- ALUCTRL_W, 4, width of alucontrol.
- MEM_HANDSHAKE, 1: 1 = memory states wait for memready; 0 = memready ignored, every memory access takes one cycle.
- CNT_W, 32, width of the instret counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low (0 = reset).
- op  in  6  instr[31:26] from instruction register.
- funct  in  6  instr[5:0].
- zero  in  1  ALU result == 0.
- ltez  in  1  srcA <= 0 (signed), from datapath.
- memready  in  1  memory completes access this cycle.
- memreq  out  1  memory access request.
- memwrite  out  1  write strobe.
- iord  out  1  0 = PC address, 1 = ALUOut address.
- irwrite  out  1  load instruction register.
- regdst  out  1  1 = rd, 0 = rt.
- memtoreg  out  1  1 = Data register, 0 = ALUOut.
- regwrite  out  1  register file write.
- alusrca  out  1  0 = PC, 1 = A.
- alusrcb  out  3  000 B, 001 const 4, 010 signimm, 011 signimm<<2, 100 zeroimm.
- pcsrc  out  2  00 ALUResult, 01 ALUOut, 10 jump target.
- pcen  out  1  PC load enable.
- alucontrol  out  ALUCTRL_W  ALU operation.
- illegal_op  out  1  one-cycle pulse on unsupported op/funct.
- instret  out  CNT_W  retired instruction count.

Behaviour:
- Reset (reset=0): state <= FETCH, instret <= 0. All outputs forced to 0 combinationally while reset=0.
- Outputs are Moore, decoded from state. Exceptions: pcen in branch states, and irwrite/pcen in FETCH.
- FETCH:
  - memreq=1, iord=0, alusrca=0, alusrcb=001, alucontrol=ADD, pcsrc=00.
  - irwrite = pcen = (memready | ~MEM_HANDSHAKE).
  - Stay in FETCH until that term is 1, then go to DECODE.
- DECODE: alusrca=0, alusrcb=011, ADD (branch target into ALUOut). Next state by op:
  - 100011 lw / 101011 sw -> MEMADR.
  - 000000 -> RTYPE.
  - 000100 -> BEQ; 000101 -> BNE; 000110 -> BLEZ.
  - 001000 -> ADDIEX; 001101 -> ORIEX.
  - 000010 -> JUMP.
  - Any other op -> ILLEGAL.
- MEMADR: alusrca=1, alusrcb=010, ADD. Next: MEMRD if lw, MEMWR if sw.
- MEMRD: memreq=1, iord=1. Hold until memready (or 1 cycle if MEM_HANDSHAKE=0), then MEMWB.
- MEMWB: regwrite=1, regdst=0, memtoreg=1 -> FETCH.
- MEMWR: memreq=1, memwrite=1, iord=1. Hold until ready, then -> FETCH. memwrite stays high throughout the wait.
- RTYPE: alusrca=1, alusrcb=000, alucontrol from funct:
  - 100000 ADD 0010, 100010 SUB 0110, 100100 AND 0000, 100101 OR 0001.
  - 100110 XOR 0011, 100111 NOR 1100, 101010 SLT 0111.
  - Recognised funct -> ALUWB; unknown funct -> ILLEGAL.
- ALUWB: regwrite=1, regdst=1, memtoreg=0 -> FETCH.
- BEQ / BNE / BLEZ: alusrca=1, alusrcb=000, SUB, pcsrc=01 -> FETCH.
  - pcen = zero (BEQ), ~zero (BNE), ltez (BLEZ).
- ADDIEX: alusrca=1, alusrcb=010, ADD -> IMMWB.
- ORIEX: alusrca=1, alusrcb=100, OR -> IMMWB.
- IMMWB: regwrite=1, regdst=0, memtoreg=0 -> FETCH.
- JUMP: pcsrc=10, pcen=1 -> FETCH.
- ILLEGAL: illegal_op=1 for exactly one cycle, no writes -> FETCH. Not counted in instret.
- instret increments by 1 on every transition into FETCH from MEMWB, MEMWR, ALUWB, IMMWB, BEQ, BNE, BLEZ or JUMP. Taken and not-taken branches both count. Wraps modulo 2^CNT_W.
- Cycle counts with memready always 1: lw 5, sw 4, R-type 4, addi/ori 4, branch 3, j 3, illegal 3.
- Reset asserted mid-instruction: immediate return to FETCH, instret cleared, no partial write after deassert.
- memready is ignored in non-memory states.

Decomposition:
- Package mips_mc_pkg holds:
  - state enum (FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPE, ALUWB, BEQ, BNE, BLEZ, ADDIEX, ORIEX, IMMWB, JUMP, ILLEGAL);
  - opcode and funct constants;
  - alucontrol encodings;
  - alusrcb/pcsrc encodings.
- One combinational sub-module, mips_mc_aludec: funct -> alucontrol plus a funct_valid flag.

Test Plan:
- Reset low for 2 cycles, then release. Drive lw (op=100011) with memready=1 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; regwrite=1 with memtoreg=1 in cycle 5; instret=1.
- sw with memready low for 3 cycles in MEMWR -> memwrite held high 4 cycles, exit on ready, instret increments once.
- beq zero=1 -> pcen=1 in BEQ; bne zero=1 -> pcen=0; blez ltez=1 -> pcen=1; instret +3 total.
- R-type funct=100111 -> alucontrol=1100 in RTYPE. funct=111111 -> illegal_op pulses 1 cycle, regwrite never asserted, instret unchanged.
- op=111111 -> ILLEGAL, return to FETCH. Then reset pulled low in MEMRD of a following lw -> all outputs 0 immediately, instret=0, FETCH after release.
- MEM_HANDSHAKE=0 with memready tied 0 -> lw completes in 5 cycles. After 2^CNT_W retirements (CNT_W=4, 16 j instructions), instret wraps to 0.
